lcd_cmd_sequencer: RTL and testbench

- Sequences the HD44780-style character LCD in 8-bit write-only mode.
- After reset it runs the fixed power-up and initialisation command sequence.
- It then accepts command and data bytes from upstream logic through a valid/ready handshake and drives `lcd_rs`, `lcd_en` and `lcd_data` with the required setup, enable-pulse and execution waits.
- Timing comes from an internal microsecond timebase derived from the system clock, so the LCD path is single-clock with no divided clocks.

---
 rtl/lcd_pkg.sv | 40 ++++
 rtl/lcd_us_timer.sv | 43 ++++
 rtl/lcd_cmd_sequencer.sv | 176 +++++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 sequencer.
// Init ROM contents, fixed init waits and command codes.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_SETUP,
        ST_EN_HIGH,
        ST_WAIT,
        ST_IDLE
    } lcd_state_e;

    localparam int INIT_LEN      = 7;
    localparam int INIT_WAIT0_US = 4100;
    localparam int INIT_WAIT1_US = 100;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;

    function automatic logic [7:0] init_byte(input logic [2:0] step);
        logic [7:0] b;
        case (step)
            3'd4:    b = CMD_DISP_ON;
            3'd5:    b = CMD_CLEAR;
            3'd6:    b = CMD_ENTRY;
            default: b = CMD_FUNC_SET;
        endcase
        return b;
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs,
                                         input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data[7:1] == CMD_HOME[7:1]);
    endfunction

endpackage

// File: rtl/lcd_us_timer.sv
// lcd_us_timer: microsecond prescaler plus microsecond down-counter.
// done pulses in the last cycle of a load_val-microsecond interval.
module lcd_us_timer
    import lcd_pkg::*;
#(
    parameter int             US_DIV  = 50,
    parameter int             TW      = 14,
    parameter logic [TW-1:0]  RST_VAL = '0
) (
    input  logic          clk_50mhz,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          done
);

    localparam int            PW      = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(US_DIV - 1);

    logic [PW-1:0] pre;
    logic [TW-1:0] cnt;

    // Restart on load; count down one microsecond per US_DIV cycles, stop at 0.
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            pre <= PRE_MAX;
            cnt <= RST_VAL;
        end else if (load) begin
            pre <= PRE_MAX;
            cnt <= load_val;
        end else if (cnt != '0) begin
            if (pre == '0) begin
                pre <= PRE_MAX;
                cnt <= cnt - TW'(1);
            end else begin
                pre <= pre - PW'(1);
            end
        end
    end

    assign done = (cnt == TW'(1)) && (pre == '0);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: HD44780 8-bit write-only power-up, init and
// request sequencer with registered LCD outputs.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int PWRUP_WAIT_US = 15000,
    parameter int CMD_WAIT_US   = 40,
    parameter int LONG_WAIT_US  = 1640
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    localparam int US_DIV = CLK_FREQ / 1_000_000;
    localparam int MAX_A  = (PWRUP_WAIT_US > INIT_WAIT0_US) ?
                            PWRUP_WAIT_US : INIT_WAIT0_US;
    localparam int MAX_B  = (LONG_WAIT_US > CMD_WAIT_US) ?
                            LONG_WAIT_US : CMD_WAIT_US;
    localparam int MAX_US = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW     = $clog2(MAX_US + 1);

    localparam logic [TW-1:0] W_PWRUP = TW'(PWRUP_WAIT_US);
    localparam logic [TW-1:0] W_CMD   = TW'(CMD_WAIT_US);
    localparam logic [TW-1:0] W_LONG  = TW'(LONG_WAIT_US);
    localparam logic [TW-1:0] W_INIT0 = TW'(INIT_WAIT0_US);
    localparam logic [TW-1:0] W_INIT1 = TW'(INIT_WAIT1_US);
    localparam logic [2:0]    LAST    = 3'(INIT_LEN - 1);

    lcd_state_e    state;
    lcd_state_e    state_nx;
    logic [2:0]    step;
    logic [2:0]    step_nx;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;
    logic [TW-1:0] wait_val;
    logic          accept;
    logic          rom_cap;
    logic          set_done;
    logic          cap_rs;
    logic [7:0]    cap_data;

    lcd_us_timer #(
        .US_DIV  (US_DIV),
        .TW      (TW),
        .RST_VAL (W_PWRUP)
    ) u_timer (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .done      (tmr_done)
    );

    // Execution wait for the byte currently on the bus.
    always_comb begin
        wait_val = W_CMD;
        if (!init_done) begin
            case (step)
                3'd0:    wait_val = W_INIT0;
                3'd1:    wait_val = W_INIT1;
                3'd5:    wait_val = W_LONG;
                default: wait_val = W_CMD;
            endcase
        end else if (is_long_cmd(lcd_rs, lcd_data)) begin
            wait_val = W_LONG;
        end
    end

    // Next-state, timer reload and capture strobes.
    always_comb begin
        state_nx = state;
        step_nx  = step;
        tmr_load = 1'b0;
        tmr_val  = TW'(1);
        accept   = 1'b0;
        rom_cap  = 1'b0;
        set_done = 1'b0;
        unique case (state)
            ST_PWRUP: begin
                if (tmr_done) begin
                    state_nx = ST_SETUP;
                    step_nx  = '0;
                    tmr_load = 1'b1;
                    rom_cap  = 1'b1;
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_nx = ST_EN_HIGH;
                    tmr_load = 1'b1;
                end
            end
            ST_EN_HIGH: begin
                if (tmr_done) begin
                    state_nx = ST_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = wait_val;
                end
            end
            ST_WAIT: begin
                if (tmr_done) begin
                    if (!init_done && step != LAST) begin
                        state_nx = ST_SETUP;
                        step_nx  = step + 3'd1;
                        tmr_load = 1'b1;
                        rom_cap  = 1'b1;
                    end else begin
                        set_done = !init_done;
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept   = 1'b1;
                    state_nx = ST_SETUP;
                    tmr_load = 1'b1;
                end
            end
            default: state_nx = ST_PWRUP;
        endcase
    end

    // Byte to present on the bus at the next SETUP entry.
    always_comb begin
        cap_rs   = lcd_rs;
        cap_data = lcd_data;
        if (accept) begin
            cap_rs   = req_rs;
            cap_data = req_data;
        end else if (rom_cap) begin
            cap_rs   = 1'b0;
            cap_data = init_byte(step_nx);
        end
    end

    // State, step index and registered LCD/handshake outputs.
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            state     <= ST_PWRUP;
            step      <= '0;
            lcd_rs    <= 1'b0;
            lcd_data  <= '0;
            lcd_en    <= 1'b0;
            lcd_rw    <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            init_done <= 1'b0;
        end else begin
            state     <= state_nx;
            step      <= step_nx;
            lcd_rs    <= cap_rs;
            lcd_data  <= cap_data;
            lcd_en    <= (state_nx == ST_EN_HIGH);
            lcd_rw    <= 1'b0;
            req_ready <= (state_nx == ST_IDLE);
            busy      <= (state_nx != ST_IDLE);
            if (set_done) begin
                init_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: directed bench for the LCD sequencer at a
// 4 MHz clock (4 cycles per microsecond) with short power-up/long waits.
module tb_lcd_cmd_sequencer;

    localparam int CF = 4_000_000;
    localparam int D  = 4;
    localparam int PW = 100;
    localparam int CW = 40;
    localparam int LW = 200;

    logic       clk_50mhz = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic [7:0] req_data;
    logic       init_done;
    logic       busy;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         wait_us;
        bit         hold;
        int         poke_k;
    } vec_t;

    vec_t       vecs [10];
    logic [7:0] rom_exp [7];
    int         rom_wait [7];
    int         exp_first_rise;
    int         exp_init_done;

    lcd_cmd_sequencer #(
        .CLK_FREQ      (CF),
        .PWRUP_WAIT_US (PW),
        .CMD_WAIT_US   (CW),
        .LONG_WAIT_US  (LW)
    ) dut (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .init_done (init_done),
        .busy      (busy),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_data  (lcd_data)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic run_init();
        int         k;
        int         pulses;
        int         first_rise;
        int         first_width;
        int         done_k;
        int         limit;
        logic       prev_en;
        logic [7:0] seen [8];
        bit         rs_bad;
        bit         rdy_done;
        bit         early_rdy;
        k = 0; pulses = 0; first_rise = -1; first_width = 0;
        done_k = -1; prev_en = 1'b0; rs_bad = 0; rdy_done = 0; early_rdy = 0;
        for (int i = 0; i < 8; i++) seen[i] = 8'h00;
        limit = exp_init_done + 200;
        @(negedge clk_50mhz);
        rst_n = 1'b1;
        while (k < limit && done_k < 0) begin
            @(negedge clk_50mhz);
            k++;
            if (lcd_en && !prev_en) begin
                if (pulses < 8) seen[pulses] = lcd_data;
                if (lcd_rs) rs_bad = 1;
                if (first_rise < 0) first_rise = k;
                pulses++;
            end
            if (lcd_en && pulses == 1) first_width++;
            prev_en = lcd_en;
            if (init_done) begin
                done_k   = k;
                rdy_done = req_ready;
            end else if (req_ready) begin
                early_rdy = 1;
            end
            if (k == 10 || k == exp_first_rise + 2 * D) begin
                req_valid = 1'b1;
                req_rs    = 1'b1;
                req_data  = 8'hAA;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        chk("init_first_en_rise", first_rise, exp_first_rise);
        chk("init_first_en_width", first_width, D);
        chk("init_pulse_count", pulses, 7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("init_byte_%0d", i), seen[i], rom_exp[i]);
        chk("init_rs_zero", rs_bad, 0);
        chk("init_done_cycle", done_k, exp_init_done);
        chk("init_ready_with_done", rdy_done, 1);
        chk("init_no_early_ready", early_rdy, 0);
    endtask

    task automatic do_write(input vec_t v, input int idx);
        int   wk;
        int   limit;
        int   first_en;
        int   en_cnt;
        int   pulses;
        int   ready_k;
        logic prev_en;
        bit   held_bad;
        bit   busy_bad;
        wk = 0;
        while (!req_ready && wk < 50000) begin
            @(negedge clk_50mhz);
            wk++;
        end
        chk($sformatf("w%0d_ready_before", idx), req_ready, 1);
        req_valid = 1'b1;
        req_rs    = v.rs;
        req_data  = v.data;
        limit = (2 + v.wait_us) * D + 100;
        first_en = -1; en_cnt = 0; pulses = 0; ready_k = -1;
        prev_en = 1'b0; held_bad = 0; busy_bad = 0;
        @(negedge clk_50mhz);
        chk($sformatf("w%0d_ready_drop", idx), req_ready, 0);
        for (int k = 0; k <= limit && ready_k < 0; k++) begin
            if (k > 0) @(negedge clk_50mhz);
            if (lcd_en) begin
                en_cnt++;
                if (!prev_en) begin
                    pulses++;
                    if (first_en < 0) first_en = k;
                end
            end
            prev_en = lcd_en;
            if (lcd_rs !== v.rs || lcd_data !== v.data) held_bad = 1;
            if (busy !== !req_ready) busy_bad = 1;
            if (req_ready) ready_k = k;
            if (v.poke_k > 0 && k == v.poke_k) begin
                req_valid = 1'b1;
                req_rs    = ~v.rs;
                req_data  = 8'hEE;
            end else if (v.hold && ready_k < 0) begin
                req_valid = 1'b1;
                req_rs    = v.rs;
                req_data  = v.data;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        chk($sformatf("w%0d_en_start", idx), first_en, D);
        chk($sformatf("w%0d_en_cycles", idx), en_cnt, D);
        chk($sformatf("w%0d_en_pulses", idx), pulses, 1);
        chk($sformatf("w%0d_ready_back", idx), ready_k, (2 + v.wait_us) * D);
        chk($sformatf("w%0d_bus_held", idx), held_bad, 0);
        chk($sformatf("w%0d_busy_vs_ready", idx), busy_bad, 0);
    endtask

    initial begin
        rom_exp  = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        rom_wait = '{4100, 100, CW, CW, CW, LW, CW};
        exp_first_rise = PW * D + D;
        exp_init_done  = PW * D;
        for (int i = 0; i < 7; i++)
            exp_init_done += (2 + rom_wait[i]) * D;

        vecs[0] = '{1'b1, 8'h41, CW, 1'b1, 0};
        vecs[1] = '{1'b0, 8'h01, LW, 1'b0, 0};
        vecs[2] = '{1'b1, 8'h01, CW, 1'b0, 0};
        vecs[3] = '{1'b0, 8'h02, LW, 1'b0, 0};
        vecs[4] = '{1'b0, 8'h03, LW, 1'b0, 0};
        vecs[5] = '{1'b0, 8'h00, CW, 1'b0, 0};
        vecs[6] = '{1'b1, 8'h00, CW, 1'b0, 0};
        vecs[7] = '{1'b0, 8'h04, CW, 1'b0, 0};
        vecs[8] = '{1'b0, 8'h80, CW, 1'b0, 2 * D + 10};
        vecs[9] = '{1'b1, 8'h02, CW, 1'b0, 0};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_data  = 8'h00;
        repeat (5) @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        chk("rst_lcd_en", lcd_en, 0);
        chk("rst_lcd_rs", lcd_rs, 0);
        chk("rst_lcd_rw", lcd_rw, 0);
        chk("rst_lcd_data", lcd_data, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_busy", busy, 1);

        run_init();

        for (int i = 0; i < 10; i++)
            do_write(vecs[i], i);

        // Reset asserted while the enable strobe of a user write is high.
        begin
            int wk;
            wk = 0;
            while (!req_ready && wk < 50000) begin
                @(negedge clk_50mhz);
                wk++;
            end
            req_valid = 1'b1;
            req_rs    = 1'b1;
            req_data  = 8'h55;
            @(negedge clk_50mhz);
            req_valid = 1'b0;
            repeat (D + 1) @(negedge clk_50mhz);
            chk("mid_en_high", lcd_en, 1);
            rst_n = 1'b0;
            @(negedge clk_50mhz);
            chk("mid_rst_en", lcd_en, 0);
            chk("mid_rst_init_done", init_done, 0);
            chk("mid_rst_ready", req_ready, 0);
            chk("mid_rst_busy", busy, 1);
            chk("mid_rst_data", lcd_data, 0);
            chk("mid_rst_rs", lcd_rs, 0);
            repeat (3) @(negedge clk_50mhz);
        end

        run_init();
        do_write(vecs[0], 10);
        chk("end_lcd_rw", lcd_rw, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
